axi_sram_wide: RTL and testbench

//  Parametrised on-chip SRAM slave on AXI4. Supports DATA_WIDTH up to 128, byte strobes,

---
 rtl/axi_sram_wide_if.sv | 43 ++++
 rtl/axi_sram_wide.sv | 208 ++++++++++++++++++++
 tb/tb_axi_sram_wide.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_wide_if.sv
// AXI4 channel bundle for axi_sram_wide: the bus master drives m_* and the SRAM drives s_*.
interface axi_sram_wide_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  m_awvalid;
  logic [31:0]           m_awadr;
  logic [7:0]            m_awlen;
  logic [1:0]            m_awburst;
  logic                  s_awready;
  logic                  m_wvalid;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [BYTES-1:0]      m_wstrb;
  logic                  s_wready;
  logic                  s_bvalid;
  logic [1:0]            s_bresp;
  logic                  m_bready;
  logic                  m_arvalid;
  logic [31:0]           m_aradr;
  logic [7:0]            m_arlen;
  logic [1:0]            m_arburst;
  logic                  s_arready;
  logic                  s_rvalid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic                  m_rready;

  modport master (
    output m_awvalid, m_awadr, m_awlen, m_awburst, m_wvalid, m_wdata, m_wstrb,
           m_bready, m_arvalid, m_aradr, m_arlen, m_arburst, m_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
           s_rresp, s_rlast
  );

  modport slave (
    input  m_awvalid, m_awadr, m_awlen, m_awburst, m_wvalid, m_wdata, m_wstrb,
           m_bready, m_arvalid, m_aradr, m_arlen, m_arburst, m_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
           s_rresp, s_rlast
  );
endinterface

// File: rtl/axi_sram_wide.sv
// AXI4 on-chip SRAM slave with byte strobes, INCR/WRAP bursts and a 32-bit preload port.
// Optional feature: define AXI_SRAM_RANGE_CHECK_EN to flag bursts whose start word is >= MEM_SIZE.
module axi_sram_wide #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 'h40000
) (
  input  logic           clk,
  input  logic           reset,
  axi_sram_wide_if.slave bus,
  input  logic           loader_we,
  input  logic [31:0]    loader_adr,
  input  logic [31:0]    loader_data
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFW   = $clog2(BYTES);
  localparam int AW     = $clog2(MEM_SIZE);
  localparam int LANES  = DATA_WIDTH / 32;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    WRITE_ACK   = 2'd2,
    READ_BURST  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_wr_q, last_wr_d;
  logic            aw_full_q, aw_full_d, ar_full_q, ar_full_d;
  logic [31:0]     aw_adr_q, aw_adr_d, ar_adr_q, ar_adr_d;
  logic [7:0]      aw_len_q, aw_len_d, ar_len_q, ar_len_d;
  logic [1:0]      aw_burst_q, aw_burst_d, ar_burst_q, ar_burst_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d, beat_q, beat_d;
  logic [1:0]      burst_q, burst_d;
  logic            rvalid_q, rvalid_d, rlast_q, rlast_d, bvalid_q, bvalid_d;
`ifdef AXI_SRAM_RANGE_CHECK_EN
  logic            err_q, err_d;
`endif
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic            rd_issue_s, wr_en_s, wr_ok_s;
  logic [AW-1:0]   rd_adr_s, ld_word_s;
  logic [LANE_W-1:0] ld_lane_s;

  // Next word of a burst; WRAP only for 2/4/8/16-beat bursts, everything else steps linearly.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [7:0] l,
                                             input logic [1:0] b);
    logic [AW-1:0] m;
    m = AW'(l);
    if (b == 2'b10 && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) begin
      next_adr = (a & ~m) | ((a + AW'(1)) & m);
    end else begin
      next_adr = a + AW'(1);
    end
  endfunction

  assign ld_word_s = AW'(loader_adr >> OFFW);
  if (LANES > 1) begin : g_lane
    assign ld_lane_s = loader_adr[2 +: LANE_W];
  end else begin : g_lane1
    assign ld_lane_s = 1'b0;
  end

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign wr_ok_s       = !err_q;
  assign bus.s_rdata   = err_q ? {DATA_WIDTH{1'b0}} : rdata_q;
  assign bus.s_rresp   = err_q ? 2'b10 : 2'b00;
  assign bus.s_bresp   = err_q ? 2'b10 : 2'b00;
`else
  assign wr_ok_s       = 1'b1;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = 2'b00;
  assign bus.s_bresp   = 2'b00;
`endif
  assign bus.s_awready = !aw_full_q;
  assign bus.s_arready = !ar_full_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rlast   = rlast_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_wready  = (state_q == WRITE_BURST) && !loader_we;

  // Next-state logic: address capture, arbitration and burst sequencing.
  always_comb begin
    state_d = state_q;   last_wr_d = last_wr_q;
    aw_full_d = aw_full_q; aw_adr_d = aw_adr_q; aw_len_d = aw_len_q; aw_burst_d = aw_burst_q;
    ar_full_d = ar_full_q; ar_adr_d = ar_adr_q; ar_len_d = ar_len_q; ar_burst_d = ar_burst_q;
    addr_d = addr_q; len_d = len_q; beat_d = beat_q; burst_d = burst_q;
    rvalid_d = rvalid_q; rlast_d = rlast_q; bvalid_d = bvalid_q;
`ifdef AXI_SRAM_RANGE_CHECK_EN
    err_d = err_q;
`endif
    rd_issue_s = 1'b0;
    rd_adr_s   = addr_q;
    wr_en_s    = 1'b0;

    if (bus.m_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1; aw_adr_d = bus.m_awadr; aw_len_d = bus.m_awlen; aw_burst_d = bus.m_awburst;
    end else begin
      aw_full_d = aw_full_q;
    end
    if (bus.m_arvalid && !ar_full_q) begin
      ar_full_d = 1'b1; ar_adr_d = bus.m_aradr; ar_len_d = bus.m_arlen; ar_burst_d = bus.m_arburst;
    end else begin
      ar_full_d = ar_full_q;
    end

    case (state_q)
      IDLE: begin
        // On a tie the channel that was not served last wins.
        if (aw_full_q && (!ar_full_q || !last_wr_q)) begin
          state_d = WRITE_BURST; aw_full_d = 1'b0; last_wr_d = 1'b1;
          addr_d = AW'(aw_adr_q >> OFFW); len_d = aw_len_q; burst_d = aw_burst_q; beat_d = 8'd0;
`ifdef AXI_SRAM_RANGE_CHECK_EN
          err_d = (aw_adr_q >> OFFW) >= 32'(MEM_SIZE);
`endif
        end else if (ar_full_q) begin
          state_d = READ_BURST; ar_full_d = 1'b0; last_wr_d = 1'b0;
          rd_issue_s = 1'b1; rd_adr_s = AW'(ar_adr_q >> OFFW);
          addr_d = next_adr(AW'(ar_adr_q >> OFFW), ar_len_q, ar_burst_q);
          len_d = ar_len_q; burst_d = ar_burst_q; beat_d = 8'd0;
          rvalid_d = 1'b1; rlast_d = (ar_len_q == 8'd0);
`ifdef AXI_SRAM_RANGE_CHECK_EN
          err_d = (ar_adr_q >> OFFW) >= 32'(MEM_SIZE);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_BURST: begin
        if (bus.m_wvalid && !loader_we) begin
          wr_en_s = wr_ok_s;
          addr_d  = next_adr(addr_q, len_q, burst_q);
          beat_d  = beat_q + 8'd1;
          if (beat_q == len_q) begin
            state_d = WRITE_ACK; bvalid_d = 1'b1;
          end else begin
            state_d = WRITE_BURST;
          end
        end else begin
          state_d = WRITE_BURST;
        end
      end
      WRITE_ACK: begin
        if (bus.m_bready) begin
          state_d = IDLE; bvalid_d = 1'b0;
        end else begin
          state_d = WRITE_ACK;
        end
      end
      READ_BURST: begin
        // rdata_q only reloads on a taken beat, so a stalled beat stays stable.
        if (rvalid_q && bus.m_rready) begin
          if (rlast_q) begin
            state_d = IDLE; rvalid_d = 1'b0; rlast_d = 1'b0;
          end else begin
            rd_issue_s = 1'b1; rd_adr_s = addr_q;
            addr_d  = next_adr(addr_q, len_q, burst_q);
            beat_d  = beat_q + 8'd1;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end else begin
          state_d = READ_BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset clears the FSM and both holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; last_wr_q <= 1'b0;
      aw_full_q <= 1'b0; aw_adr_q <= 32'd0; aw_len_q <= 8'd0; aw_burst_q <= 2'b00;
      ar_full_q <= 1'b0; ar_adr_q <= 32'd0; ar_len_q <= 8'd0; ar_burst_q <= 2'b00;
      addr_q <= {AW{1'b0}}; len_q <= 8'd0; beat_q <= 8'd0; burst_q <= 2'b00;
      rvalid_q <= 1'b0; rlast_q <= 1'b0; bvalid_q <= 1'b0;
`ifdef AXI_SRAM_RANGE_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; last_wr_q <= last_wr_d;
      aw_full_q <= aw_full_d; aw_adr_q <= aw_adr_d; aw_len_q <= aw_len_d; aw_burst_q <= aw_burst_d;
      ar_full_q <= ar_full_d; ar_adr_q <= ar_adr_d; ar_len_q <= ar_len_d; ar_burst_q <= ar_burst_d;
      addr_q <= addr_d; len_q <= len_d; beat_q <= beat_d; burst_q <= burst_d;
      rvalid_q <= rvalid_d; rlast_q <= rlast_d; bvalid_q <= bvalid_d;
`ifdef AXI_SRAM_RANGE_CHECK_EN
      err_q <= err_d;
`endif
    end
  end

  // SRAM array: loader has priority over AXI writes; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (loader_we) begin
      mem[ld_word_s][32*ld_lane_s +: 32] <= loader_data;
    end else if (wr_en_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.m_wstrb[i]) begin
          mem[addr_q][i*8 +: 8] <= bus.m_wdata[i*8 +: 8];
        end
      end
    end
    if (rd_issue_s) begin
      rdata_q <= mem[rd_adr_s];
    end
  end
endmodule

// File: tb/tb_axi_sram_wide.sv
// Directed scoreboard bench for axi_sram_wide (64-bit data, 256-word memory).
module tb_axi_sram_wide;
  localparam int DW = 64;
  localparam int MS = 256;
`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic        is_r;
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        loader_we = 1'b0;
  logic [31:0] loader_adr = 32'd0;
  logic [31:0] loader_data = 32'd0;
  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          rr_mode = 0;
  logic [63:0] wd [16];
  logic [7:0]  ws [16];

  axi_sram_wide_if #(.DATA_WIDTH(DW)) bus();

  axi_sram_wide #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .loader_we(loader_we), .loader_adr(loader_adr), .loader_data(loader_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    vectors++; miscompares++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_r(input logic [63:0] d, input logic l, input logic [1:0] r);
    sbq.push_back('{is_r: 1'b1, data: d, last: l, resp: r});
  endtask

  task automatic push_b(input logic [1:0] r);
    sbq.push_back('{is_r: 1'b0, data: 64'd0, last: 1'b0, resp: r});
  endtask

  task automatic send_a(input bit rd, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    if (rd) begin bus.m_arvalid = 1'b1; bus.m_aradr = a; bus.m_arlen = l; bus.m_arburst = b; end
    else    begin bus.m_awvalid = 1'b1; bus.m_awadr = a; bus.m_awlen = l; bus.m_awburst = b; end
    @(negedge clk);
    while (!(rd ? bus.s_arready : bus.s_awready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail(rd ? "ar_ready" : "aw_ready");
    cyc();
    bus.m_arvalid = 1'b0; bus.m_awvalid = 1'b0;
  endtask

  task automatic send_w(input int beats);
    for (int k = 0; k < beats; k++) begin
      int n = 0;
      bus.m_wvalid = 1'b1; bus.m_wdata = wd[k]; bus.m_wstrb = ws[k];
      @(negedge clk);
      while (!bus.s_wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout_fail("w_ready");
      cyc();
    end
    bus.m_wvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin cyc(); n++; end
    if (sbq.size() != 0) begin timeout_fail("drain"); sbq.delete(); end
    cyc();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    loader_we = 1'b1; loader_adr = a; loader_data = d;
    cyc();
    loader_we = 1'b0;
  endtask

  initial begin
    bus.m_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0) bus.m_rready = 1'b1;
      else if (rr_mode == 1) bus.m_rready = ~bus.m_rready;
      else bus.m_rready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks stalled-beat stability.
  initial begin
    logic        hold_v;
    logic [63:0] hold_d;
    exp_t        e;
    hold_v = 1'b0; hold_d = 64'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && bus.s_rvalid) chk("rdata_hold", bus.s_rdata, hold_d);
        hold_v = bus.s_rvalid && !bus.m_rready;
        hold_d = bus.s_rdata;
        if (bus.s_rvalid && bus.m_rready) begin
          if (sbq.size() == 0) timeout_fail("r_unexpected");
          else begin
            e = sbq.pop_front();
            chk("r_order", 64'd1, 64'(e.is_r));
            chk("rdata", bus.s_rdata, e.data);
            chk("rlast", 64'(bus.s_rlast), 64'(e.last));
            chk("rresp", 64'(bus.s_rresp), 64'(e.resp));
          end
        end
        if (bus.s_bvalid && bus.m_bready) begin
          if (sbq.size() == 0) timeout_fail("b_unexpected");
          else begin
            e = sbq.pop_front();
            chk("b_order", 64'd0, 64'(e.is_r));
            chk("bresp", 64'(bus.s_bresp), 64'(e.resp));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.m_awvalid = 1'b0; bus.m_awadr = 32'd0; bus.m_awlen = 8'd0; bus.m_awburst = 2'b01;
    bus.m_arvalid = 1'b0; bus.m_aradr = 32'd0; bus.m_arlen = 8'd0; bus.m_arburst = 2'b01;
    bus.m_wvalid = 1'b0; bus.m_wdata = 64'd0; bus.m_wstrb = 8'h00; bus.m_bready = 1'b1;
    cyc(); cyc();
    // Preload while reset is held, then check reset outputs.
    load(32'h10, 32'hDEADBEEF); load(32'h14, 32'hCAFEF00D);
    load(32'h08, 32'hBBBBBBBB); load(32'h0C, 32'hAAAAAAAA);
    @(negedge clk);
    chk("rst_awready", 64'(bus.s_awready), 64'd1);
    chk("rst_arready", 64'(bus.s_arready), 64'd1);
    chk("rst_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("rst_bvalid", 64'(bus.s_bvalid), 64'd0);
    cyc(); reset = 1'b0; cyc();

    push_r(64'hCAFEF00D_DEADBEEF, 1'b1, 2'b00);
    send_a(1'b1, 32'h10, 8'd0, 2'b01); drain();

    // INCR write with partial strobe on beat 2.
    for (int k = 0; k < 4; k++) begin wd[k] = 64'hF0F0F0F0_00000001 + 64'(k); ws[k] = 8'hFF; end
    ws[1] = 8'h0F;
    push_b(2'b00); send_a(1'b0, 32'h0, 8'd3, 2'b01); send_w(4); drain();
    push_r(64'hF0F0F0F0_00000001, 1'b0, 2'b00); push_r(64'hAAAAAAAA_00000002, 1'b0, 2'b00);
    push_r(64'hF0F0F0F0_00000003, 1'b0, 2'b00); push_r(64'hF0F0F0F0_00000004, 1'b1, 2'b00);
    send_a(1'b1, 32'h0, 8'd3, 2'b01); drain();

    // WRAP len3 at word 2: words 2,3,0,1; read back with rready toggling.
    for (int k = 0; k < 4; k++) begin wd[k] = 64'hA5A5A5A5_000000A0 + 64'(k); ws[k] = 8'hFF; end
    push_b(2'b00); send_a(1'b0, 32'h10, 8'd3, 2'b10); send_w(4); drain();
    rr_mode = 1;
    push_r(64'hA5A5A5A5_000000A0, 1'b0, 2'b00); push_r(64'hA5A5A5A5_000000A1, 1'b0, 2'b00);
    push_r(64'hA5A5A5A5_000000A2, 1'b0, 2'b00); push_r(64'hA5A5A5A5_000000A3, 1'b1, 2'b00);
    send_a(1'b1, 32'h10, 8'd3, 2'b10); drain();
    push_r(64'hA5A5A5A5_000000A2, 1'b0, 2'b00); push_r(64'hA5A5A5A5_000000A3, 1'b0, 2'b00);
    push_r(64'hA5A5A5A5_000000A0, 1'b0, 2'b00); push_r(64'hA5A5A5A5_000000A1, 1'b1, 2'b00);
    send_a(1'b1, 32'h0, 8'd3, 2'b01); drain();
    rr_mode = 0; cyc(); cyc();

    // Simultaneous AW/AR twice after reset: write, read, write, read.
    reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();
    for (int p = 0; p < 2; p++) begin
      wd[0] = (p == 0) ? 64'h44444444_44444444 : 64'h55555555_55555555; ws[0] = 8'hFF;
      push_b(2'b00); push_r(wd[0], 1'b1, 2'b00);
      bus.m_awvalid = 1'b1; bus.m_awadr = 32'h20; bus.m_awlen = 8'd0; bus.m_awburst = 2'b01;
      bus.m_arvalid = 1'b1; bus.m_aradr = 32'h20; bus.m_arlen = 8'd0; bus.m_arburst = 2'b01;
      cyc();
      bus.m_awvalid = 1'b0; bus.m_arvalid = 1'b0;
      @(negedge clk);
      chk("hold_awready", 64'(bus.s_awready), 64'd0);
      chk("hold_arready", 64'(bus.s_arready), 64'd0);
      cyc(); send_w(1); drain();
    end

    // Loader stalls the W channel for three cycles mid-burst.
    for (int k = 0; k < 4; k++) begin wd[k] = 64'h80000000_00000010 + 64'(k); ws[k] = 8'hFF; end
    push_b(2'b00); send_a(1'b0, 32'h40, 8'd3, 2'b01); cyc();
    bus.m_wvalid = 1'b1; bus.m_wdata = wd[0]; bus.m_wstrb = ws[0];
    for (int k = 0; k < 3; k++) begin
      loader_we = 1'b1; loader_adr = (k == 1) ? 32'h64 : 32'h60;
      loader_data = (k == 0) ? 32'h11111111 : ((k == 1) ? 32'h22222222 : 32'h33333333);
      @(negedge clk);
      chk("wready_loader", 64'(bus.s_wready), 64'd0);
      cyc();
    end
    loader_we = 1'b0;
    send_w(4); drain();
    for (int k = 0; k < 4; k++) push_r(wd[k], 1'b0, 2'b00);
    push_r(64'h22222222_33333333, 1'b1, 2'b00);
    send_a(1'b1, 32'h40, 8'd4, 2'b01); drain();

    // Reset in the middle of a stalled read burst.
    rr_mode = 2; cyc(); cyc();
    send_a(1'b1, 32'h0, 8'd3, 2'b01);
    n = 0;
    @(negedge clk);
    while (!bus.s_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_pre_reset", 64'(bus.s_rvalid), 64'd1);
    cyc(); reset = 1'b1;
    @(negedge clk);
    chk("rvalid_in_reset", 64'(bus.s_rvalid), 64'd0);
    chk("arready_in_reset", 64'(bus.s_arready), 64'd1);
    cyc(); reset = 1'b0; rr_mode = 0; cyc(); cyc();

    // WRAP with len 2 and FIXED both step linearly.
    for (int k = 0; k < 3; k++) begin wd[k] = 64'h66660000_00000000 + 64'(k); ws[k] = 8'hFF; end
    push_b(2'b00); send_a(1'b0, 32'h28, 8'd2, 2'b10); send_w(3); drain();
    push_r(wd[0], 1'b0, 2'b00); push_r(wd[1], 1'b0, 2'b00); push_r(wd[2], 1'b1, 2'b00);
    send_a(1'b1, 32'h28, 8'd2, 2'b00); drain();

    // Start word == MEM_SIZE: modulo wrap, or error responses with the range check.
    push_r(RC ? 64'd0 : 64'hA5A5A5A5_000000A2, 1'b0, RC ? 2'b10 : 2'b00);
    push_r(RC ? 64'd0 : 64'hA5A5A5A5_000000A3, 1'b1, RC ? 2'b10 : 2'b00);
    send_a(1'b1, 32'h800, 8'd1, 2'b01); drain();
    wd[0] = 64'h77777777_77777777; ws[0] = 8'hFF;
    push_b(RC ? 2'b10 : 2'b00); send_a(1'b0, 32'h800, 8'd0, 2'b01); send_w(1); drain();
    push_r(RC ? 64'hA5A5A5A5_000000A2 : 64'h77777777_77777777, 1'b1, 2'b00);
    send_a(1'b1, 32'h0, 8'd0, 2'b01); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
